// File: rtl/reset_sequencer.sv
// Reset sequencer: merges lock-loss, debounced button and software requests,
// holds every output for a minimum time, then releases the outputs one stage at a time.
module reset_sequencer #(
    parameter int NUM_STAGES      = 4,
    parameter int HOLD_CYCLES     = 256,
    parameter int STAGE_GAP       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  btn_reset,
    input  logic                  sw_reset,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_released,
    output logic [2:0]            cause
);

    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int GAP_W  = (STAGE_GAP > 1)       ? $clog2(STAGE_GAP)       : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IDX_W  = (NUM_STAGES > 1)      ? $clog2(NUM_STAGES)      : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] locked_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;
    logic [DB_W-1:0]        db_cnt;
    logic                   btn_db;
    logic [2:0]             trig;
    logic                   trig_active;

    state_t                 state, state_nxt;
    logic [NUM_STAGES-1:0]  rst_nxt;
    logic                   all_nxt;
    logic [2:0]             cause_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [GAP_W-1:0]       gap_cnt, gap_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;

    // Input synchronisers and button debounce
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_sync <= '0;
            btn_sync    <= '0;
            db_cnt      <= '0;
            btn_db      <= 1'b0;
        end else begin
            locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
            btn_sync    <= {btn_sync[SYNC_STAGES-2:0], btn_reset};
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign locked_s    = locked_sync[SYNC_STAGES-1];
    assign btn_s       = btn_sync[SYNC_STAGES-1];
    assign trig        = {sw_reset, btn_db, ~locked_s};
    assign trig_active = |trig;

    // Sequencer state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ASSERT;
            rst_out      <= '1;
            all_released <= 1'b0;
            cause        <= 3'b000;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            idx          <= '0;
        end else begin
            state        <= state_nxt;
            rst_out      <= rst_nxt;
            all_released <= all_nxt;
            cause        <= cause_nxt;
            hold_cnt     <= hold_nxt;
            gap_cnt      <= gap_nxt;
            idx          <= idx_nxt;
        end
    end

    // Trigger overrides everything; counters stop at their terminal values
    always_comb begin
        state_nxt = state;
        rst_nxt   = rst_out;
        all_nxt   = all_released;
        cause_nxt = cause;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        if (trig_active) begin
            state_nxt = ASSERT;
            rst_nxt   = '1;
            all_nxt   = 1'b0;
            cause_nxt = (state == ASSERT) ? (cause | trig) : trig;
        end else begin
            case (state)
                ASSERT: begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rst_nxt[0] = 1'b0;
                        gap_nxt    = '0;
                        idx_nxt    = IDX_W'(1);
                        if (NUM_STAGES == 1) begin
                            state_nxt = RUN;
                            all_nxt   = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        rst_nxt[idx] = 1'b0;
                        gap_nxt      = '0;
                        if (idx == IDX_LAST) begin
                            state_nxt = RUN;
                            all_nxt   = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a table of {inputs, cycles, expected outputs}
// rows applied in order, plus a hand-written release-latency measurement at the end.
module tb_reset_sequencer;

    localparam int NS  = 4;
    localparam int HC  = 8;
    localparam int SG  = 4;
    localparam int SS  = 2;
    localparam int DBC = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          locked;
    logic          btn_reset;
    logic          sw_reset;
    logic [NS-1:0] rst_out;
    logic          all_released;
    logic [2:0]    cause;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_STAGES      (NS),
        .HOLD_CYCLES     (HC),
        .STAGE_GAP       (SG),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .locked       (locked),
        .btn_reset    (btn_reset),
        .sw_reset     (sw_reset),
        .rst_out      (rst_out),
        .all_released (all_released),
        .cause        (cause)
    );

    typedef struct {
        int         n;
        logic       rs;
        logic       lk;
        logic       bt;
        logic       sw;
        logic       every;
        logic [3:0] r;
        logic       a;
        logic [2:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int n, input logic rs, input logic lk, input logic bt,
                                input logic sw, input logic every, input logic [3:0] r,
                                input logic a, input logic [2:0] c);
        vec_t v;
        v.n = n; v.rs = rs; v.lk = lk; v.bt = bt; v.sw = sw;
        v.every = every; v.r = r; v.a = a; v.c = c;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // One clock, then the structural invariants of the outputs
    task automatic step();
        logic [3:0] nr;
        @(posedge clock);
        #1;
        cyc++;
        nr = ~rst_out;
        chk("monotone", int'((nr & (nr + 4'd1)) == 4'd0), 1);
        chk("all_released_vs_rst_out", int'(all_released), int'(rst_out == 4'd0));
    endtask

    task automatic compare(input int i);
        chk($sformatf("row%0d rst_out", i), int'(rst_out), int'(tbl[i].r));
        chk($sformatf("row%0d all_released", i), int'(all_released), int'(tbl[i].a));
        chk($sformatf("row%0d cause", i), int'(cause), int'(tbl[i].c));
    endtask

    initial begin
        int lat;
        reset = 1'b1; locked = 1'b1; btn_reset = 1'b0; sw_reset = 1'b0;

        //                n  rs lk bt sw ev  rst_out  all cause          cycle after row
        tbl.push_back(mk( 3, 1, 1, 0, 0, 1, 4'b1111, 0, 3'b000)); //   3 port reset
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1111, 0, 3'b001)); //   4 sync fill = lock loss
        tbl.push_back(mk( 9, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b001)); //  13
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b001)); //  14
        tbl.push_back(mk( 3, 0, 1, 0, 0, 1, 4'b1110, 0, 3'b001)); //  17
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1100, 0, 3'b001)); //  18
        tbl.push_back(mk( 4, 0, 1, 0, 0, 0, 4'b1000, 0, 3'b001)); //  22
        tbl.push_back(mk( 3, 0, 1, 0, 0, 1, 4'b1000, 0, 3'b001)); //  25
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b001)); //  26
        tbl.push_back(mk( 4, 0, 1, 0, 0, 1, 4'b0000, 1, 3'b001)); //  30 RUN
        tbl.push_back(mk( 1, 0, 1, 0, 1, 0, 4'b1111, 0, 3'b100)); //  31 sw pulse at 30
        tbl.push_back(mk( 8, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b100)); //  39
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b100)); //  40 = t+10
        tbl.push_back(mk(11, 0, 1, 0, 0, 0, 4'b1000, 0, 3'b100)); //  51
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b100)); //  52 = t+22
        tbl.push_back(mk( 3, 0, 1, 1, 0, 1, 4'b0000, 1, 3'b100)); //  55 3-cycle glitch
        tbl.push_back(mk(10, 0, 1, 0, 0, 1, 4'b0000, 1, 3'b100)); //  65 no effect
        tbl.push_back(mk( 6, 0, 1, 1, 0, 1, 4'b0000, 1, 3'b100)); //  71 button from 65
        tbl.push_back(mk( 1, 0, 1, 1, 0, 0, 4'b1111, 0, 3'b010)); //  72 = t+7
        tbl.push_back(mk(13, 0, 1, 1, 0, 1, 4'b1111, 0, 3'b010)); //  85 held 20 cycles
        tbl.push_back(mk(14, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b010)); //  99 btn_db last high 90
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b010)); // 100
        tbl.push_back(mk( 5, 0, 1, 0, 0, 0, 4'b1100, 0, 3'b010)); // 105 mid RELEASE
        tbl.push_back(mk( 2, 0, 0, 0, 0, 1, 4'b1100, 0, 3'b010)); // 107 lock lost at 105
        tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 4'b1111, 0, 3'b001)); // 108 = t+3, overwrite
        tbl.push_back(mk( 4, 0, 0, 0, 0, 1, 4'b1111, 0, 3'b001)); // 112
        tbl.push_back(mk(10, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b001)); // 122 lock back at 112
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b001)); // 123 (last trig cycle 113)
        tbl.push_back(mk(12, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b001)); // 135
        tbl.push_back(mk(20, 0, 1, 0, 1, 1, 4'b1111, 0, 3'b100)); // 155 sw held 135..154
        tbl.push_back(mk( 8, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b100)); // 163
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b100)); // 164 = t+29
        tbl.push_back(mk( 3, 0, 0, 0, 0, 0, 4'b1111, 0, 3'b001)); // 167 lock lost at 164
        tbl.push_back(mk( 1, 0, 0, 0, 1, 0, 4'b1111, 0, 3'b101)); // 168 sw while ASSERT
        tbl.push_back(mk( 3, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b101)); // 171
        tbl.push_back(mk( 7, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b101)); // 178
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b101)); // 179
        tbl.push_back(mk(12, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b101)); // 191 RUN
        tbl.push_back(mk( 1, 0, 1, 0, 1, 0, 4'b1111, 0, 3'b100)); // 192 overwrite from RUN
        tbl.push_back(mk( 8, 0, 1, 0, 0, 1, 4'b1111, 0, 3'b100)); // 200
        tbl.push_back(mk( 1, 0, 1, 0, 0, 0, 4'b1110, 0, 3'b100)); // 201
        tbl.push_back(mk(12, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b100)); // 213
        tbl.push_back(mk( 1, 1, 1, 0, 0, 0, 4'b1111, 0, 3'b000)); // 214 port reset in RUN
        tbl.push_back(mk( 2, 1, 1, 0, 0, 1, 4'b1111, 0, 3'b000)); // 216

        for (int i = 0; i < tbl.size(); i++) begin
            reset     = tbl[i].rs;
            locked    = tbl[i].lk;
            btn_reset = tbl[i].bt;
            sw_reset  = tbl[i].sw;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                if (tbl[i].every || k == tbl[i].n - 1) compare(i);
            end
        end

        // Release from port reset: first stage 11 cycles later, last stage 12 after that
        reset = 1'b0;
        lat = 0;
        while (rst_out[0] && lat < 40) begin
            step();
            lat++;
        end
        chk("first_release_latency", lat, 11);
        chk("cause_after_release", int'(cause), 1);
        lat = 0;
        while (!all_released && lat < 40) begin
            step();
            lat++;
        end
        chk("all_released_latency", lat, 3 * SG);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
